// File: rtl/bsg_link_sdr_traffic_node.sv
// Traffic generator and checker for SDR link channels: emits a deterministic
// counter or walking-one pattern on valid/yumi and checks it on valid/ready.
module bsg_link_sdr_traffic_node #(
  parameter int unsigned num_channels_p   = 8,
  parameter int unsigned channel_width_p  = 4,
  parameter int unsigned count_width_p    = 32,
  localparam int unsigned width_lp        = num_channels_p * channel_width_p,
  localparam int unsigned chan_id_width_lp =
    (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        clear_i,
  input  logic                        en_i,
  input  logic                        mode_i,
  input  logic [count_width_p-1:0]    limit_i,
  output logic                        v_o,
  output logic [width_lp-1:0]         data_o,
  input  logic                        yumi_i,
  input  logic                        v_i,
  input  logic [width_lp-1:0]         data_i,
  output logic                        ready_o,
  output logic [count_width_p-1:0]    sent_o,
  output logic [count_width_p-1:0]    received_o,
  output logic                        error_o,
  output logic [chan_id_width_lp-1:0] error_chan_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_RUN,
    GEN_DONE
  } gen_state_e;

  gen_state_e                  gen_state_q, gen_state_d;
  logic [width_lp-1:0]         gen_word_q, gen_word_d;
  logic [width_lp-1:0]         chk_word_q, chk_word_d;
  logic [count_width_p-1:0]    sent_q, sent_d;
  logic [count_width_p-1:0]    received_q, received_d;
  logic                        mode_q, mode_d;
  logic                        ready_q, ready_d;
  logic                        error_q, error_d;
  logic [chan_id_width_lp-1:0] error_chan_q, error_chan_d;

  logic                        limit_hit;
  logic                        chk_fire;
  logic                        bad;
  logic [chan_id_width_lp-1:0] bad_chan;

  // Beat 0 of either pattern; slices are indexed from channel 0 at the LSBs.
  function automatic logic [width_lp-1:0] seed_word(input logic m);
    logic [width_lp-1:0] w;
    w = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      if (m)
        w[c*channel_width_p +: channel_width_p] =
          channel_width_p'(1) << (c % channel_width_p);
      else
        w[c*channel_width_p +: channel_width_p] = channel_width_p'(c);
    end
    return w;
  endfunction

  function automatic logic [width_lp-1:0] advance_word(
    input logic m, input logic [width_lp-1:0] w_in);
    logic [width_lp-1:0]        w;
    logic [channel_width_p-1:0] s;
    w = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      s = w_in[c*channel_width_p +: channel_width_p];
      if (m)
        w[c*channel_width_p +: channel_width_p] =
          {s[channel_width_p-2:0], s[channel_width_p-1]};
      else
        w[c*channel_width_p +: channel_width_p] = s + channel_width_p'(1);
    end
    return w;
  endfunction

  function automatic logic [count_width_p-1:0] sat_inc(
    input logic [count_width_p-1:0] x);
    return (x == '1) ? x : x + count_width_p'(1);
  endfunction

  assign limit_hit = (limit_i != '0) && (sent_q >= limit_i);
  assign chk_fire  = v_i & ready_q;

  // Walk channels high to low so the lowest mismatching index wins.
  always_comb begin
    bad      = 1'b0;
    bad_chan = '0;
    for (int unsigned i = num_channels_p; i > 0; i--) begin
      if (data_i[(i-1)*channel_width_p +: channel_width_p] !=
          chk_word_q[(i-1)*channel_width_p +: channel_width_p]) begin
        bad      = 1'b1;
        bad_chan = chan_id_width_lp'(i - 1);
      end
    end
  end

  always_comb begin
    gen_state_d  = gen_state_q;
    gen_word_d   = gen_word_q;
    chk_word_d   = chk_word_q;
    sent_d       = sent_q;
    received_d   = received_q;
    mode_d       = mode_q;
    ready_d      = 1'b1;
    error_d      = error_q;
    error_chan_d = error_chan_q;

    case (gen_state_q)
      GEN_IDLE: begin
        if (en_i && !limit_hit) gen_state_d = GEN_RUN;
      end
      GEN_RUN: begin
        if (yumi_i) begin
          sent_d     = sat_inc(sent_q);
          gen_word_d = advance_word(mode_q, gen_word_q);
          if ((limit_i != '0) && (sent_d == limit_i))
            gen_state_d = GEN_DONE;
          else if (!en_i)
            gen_state_d = GEN_IDLE;
        end
      end
      GEN_DONE: gen_state_d = GEN_DONE;
      default:  gen_state_d = GEN_IDLE;
    endcase

    if (chk_fire) begin
      received_d = sat_inc(received_q);
      chk_word_d = advance_word(mode_q, chk_word_q);
      if (bad && !error_q) begin
        error_d      = 1'b1;
        error_chan_d = bad_chan;
      end
    end

    if (clear_i) begin
      gen_state_d  = GEN_IDLE;
      mode_d       = mode_i;
      gen_word_d   = seed_word(mode_i);
      chk_word_d   = seed_word(mode_i);
      sent_d       = '0;
      received_d   = '0;
      error_d      = 1'b0;
      error_chan_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gen_state_q  <= GEN_IDLE;
      gen_word_q   <= seed_word(1'b0);
      chk_word_q   <= seed_word(1'b0);
      sent_q       <= '0;
      received_q   <= '0;
      mode_q       <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      error_chan_q <= '0;
    end else begin
      gen_state_q  <= gen_state_d;
      gen_word_q   <= gen_word_d;
      chk_word_q   <= chk_word_d;
      sent_q       <= sent_d;
      received_q   <= received_d;
      mode_q       <= mode_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      error_chan_q <= error_chan_d;
    end
  end

  assign v_o          = (gen_state_q == GEN_RUN);
  assign done_o       = (gen_state_q == GEN_DONE);
  assign data_o       = gen_word_q;
  assign ready_o      = ready_q;
  assign sent_o       = sent_q;
  assign received_o   = received_q;
  assign error_o      = error_q;
  assign error_chan_o = error_chan_q;

endmodule

// File: tb/tb_bsg_link_sdr_traffic_node.sv
// Directed bench for bsg_link_sdr_traffic_node in 8x4 loopback configuration.
module tb_bsg_link_sdr_traffic_node;

  logic        clk = 1'b0;
  logic        reset_n, clear, en, mode;
  logic [31:0] limit;
  logic        v_o, yumi, v_i, ready, error, done;
  logic [31:0] data_o, data_i, sent, received;
  logic [2:0]  error_chan;

  logic        auto_yumi, yumi_drv;
  logic [31:0] corrupt;

  int checks   = 0;
  int failures = 0;

  int unsigned hs, vcount;
  int          first_cyc, last_cyc;
  logic [31:0] got [0:255];

  assign yumi   = auto_yumi ? v_o : yumi_drv;
  assign v_i    = v_o & yumi;
  assign data_i = data_o ^ corrupt;

  always #5 clk = ~clk;

  bsg_link_sdr_traffic_node #(
    .num_channels_p (8),
    .channel_width_p(4),
    .count_width_p  (32)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .clear_i     (clear),
    .en_i        (en),
    .mode_i      (mode),
    .limit_i     (limit),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi),
    .v_i         (v_i),
    .data_i      (data_i),
    .ready_o     (ready),
    .sent_o      (sent),
    .received_o  (received),
    .error_o     (error),
    .error_chan_o(error_chan),
    .done_o      (done)
  );

  typedef struct {
    logic        en;
    logic        yumi;
    logic        exp_v;
    logic [31:0] exp_data;
    logic        exp_done;
    logic [31:0] exp_sent;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic m, input int unsigned k);
    logic [31:0] w;
    w = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      if (m) w[c*4 +: 4] = 4'(1 << ((c + k) % 4));
      else   w[c*4 +: 4] = 4'((c + k) % 16);
    end
    return w;
  endfunction

  task automatic check_cleared_outputs(input string tag, input logic exp_ready);
    chk({tag, "_v"},        {31'd0, v_o},        32'd0);
    chk({tag, "_ready"},    {31'd0, ready},      {31'd0, exp_ready});
    chk({tag, "_sent"},     sent,                32'd0);
    chk({tag, "_received"}, received,            32'd0);
    chk({tag, "_error"},    {31'd0, error},      32'd0);
    chk({tag, "_chan"},     {29'd0, error_chan}, 32'd0);
    chk({tag, "_done"},     {31'd0, done},       32'd0);
  endtask

  task automatic do_clear(input logic m);
    @(negedge clk);
    en = 1'b0; auto_yumi = 1'b0; yumi_drv = 1'b0; corrupt = '0;
    clear = 1'b1; mode = m;
    @(negedge clk);
    clear = 1'b0;
    check_cleared_outputs("clear", 1'b1);
  endtask

  // Loopback with yumi = v_o until done_o; every accepted word checked against the model.
  task automatic run_auto(input logic m, input int max_cycles);
    hs = 0; vcount = 0; first_cyc = -1; last_cyc = -1;
    auto_yumi = 1'b1; en = 1'b1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (done) break;
      if (v_o) begin
        got[hs[7:0]] = data_o;
        chk("gen_data", data_o, exp_word(m, hs));
        vcount++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        hs++;
      end
    end
    en = 1'b0; auto_yumi = 1'b0;
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  logic [3:0] walk_c0 [5];
  logic       prev_v, prev_yumi;
  logic [31:0] prev_data;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Walking-one, limit 3: en dropped with yumi low, re-enable, then DONE.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h84218421, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h84218421, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h18421842, 1'b0, 32'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h18421842, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h18421842, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'd2};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h21842184, 1'b0, 32'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'd3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'd3};
    walk_c0 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

    reset_n = 1'b0; clear = 1'b0; en = 1'b0; mode = 1'b0; limit = '0;
    auto_yumi = 1'b0; yumi_drv = 1'b0; corrupt = '0;
    #1;
    check_cleared_outputs("reset", 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ready}, 32'd1);
    chk("idle_after_reset",  {31'd0, v_o},   32'd0);

    // Counter mode, limit 100, full-throughput loopback.
    do_clear(1'b0);
    limit = 32'd100;
    run_auto(1'b0, 400);
    chk("t1_sent",     sent,     32'd100);
    chk("t1_received", received, 32'd100);
    chk("t1_error",    {31'd0, error}, 32'd0);
    chk("t1_vcount",   vcount,   32'd100);
    chk("t1_v_span",   32'(last_cyc - first_cyc + 1), 32'd100);
    chk("t1_beat0",    got[0],   32'h76543210);
    chk("t1_beat99",   got[99],  32'hA9876543);
    @(negedge clk);
    chk("t1_done_held", {31'd0, done}, 32'd1);
    chk("t1_v_low",     {31'd0, v_o},  32'd0);

    // Table-driven walking-one sequence.
    do_clear(1'b1);
    limit = 32'd3;
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en; yumi_drv = tbl[i].yumi;
      #1;
      chk($sformatf("tbl%0d_v", i),    {31'd0, v_o},  {31'd0, tbl[i].exp_v});
      chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].exp_done});
      chk($sformatf("tbl%0d_sent", i), sent,          tbl[i].exp_sent);
      chk($sformatf("tbl%0d_recv", i), received,      tbl[i].exp_sent);
      chk($sformatf("tbl%0d_err", i),  {31'd0, error}, 32'd0);
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
      @(negedge clk);
    end
    yumi_drv = 1'b0;

    // Walking-one channel 0 over five beats.
    do_clear(1'b1);
    limit = 32'd5;
    run_auto(1'b1, 50);
    for (int b = 0; b < 5; b++)
      chk($sformatf("walk_c0_beat%0d", b), {28'd0, got[b][3:0]}, {28'd0, walk_c0[b]});
    chk("walk_c1_beat0", {28'd0, got[0][7:4]}, 32'h2);

    // Random yumi, unlimited: hold-stable and count agreement.
    do_clear(1'b0);
    limit = '0; en = 1'b1; hs = 0; prev_v = 1'b0; prev_yumi = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (prev_v && !prev_yumi) begin
        chk("rand_v_hold",    {31'd0, v_o}, 32'd1);
        chk("rand_data_hold", data_o,       prev_data);
      end
      yumi_drv = 1'b0;
      if (v_o) begin
        chk("rand_data", data_o, exp_word(1'b0, hs));
        if (hs == 0) chk("rand_first_word",  data_o, 32'h76543210);
        if (hs == 1) chk("rand_second_word", data_o, 32'h87654321);
        yumi_drv = 1'($urandom_range(0, 1));
        if (yumi_drv) hs++;
      end
      prev_v = v_o; prev_yumi = yumi_drv; prev_data = data_o;
    end
    en = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      yumi_drv = v_o;
      if (v_o) hs++;
      else break;
    end
    @(negedge clk);
    yumi_drv = 1'b0;
    chk("rand_sent",     sent,     hs);
    chk("rand_received", received, hs);
    chk("rand_error",    {31'd0, error}, 32'd0);
    chk("rand_idle",     {31'd0, v_o},   32'd0);

    // Corrupt beat 10 on channel 5 and beat 20 on channel 2.
    do_clear(1'b0);
    limit = 32'd30; en = 1'b1; auto_yumi = 1'b1; hs = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      chk("inj_error", {31'd0, error}, {31'd0, (hs >= 11)});
      if (hs >= 11) chk("inj_chan", {29'd0, error_chan}, 32'd5);
      if (done) break;
      corrupt = '0;
      if (v_o && hs == 10) corrupt = 32'h1 << 20;
      if (v_o && hs == 20) corrupt = 32'h1 << 8;
      if (v_o) hs++;
    end
    en = 1'b0; auto_yumi = 1'b0; corrupt = '0;
    chk("inj_received", received, 32'd30);
    chk("inj_error_end", {31'd0, error}, 32'd1);
    chk("inj_chan_end",  {29'd0, error_chan}, 32'd5);

    // Asynchronous reset mid-run, with an error already latched.
    do_clear(1'b0);
    limit = '0; en = 1'b1; auto_yumi = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      corrupt = (cyc == 2) ? 32'h1 : 32'h0;
    end
    @(negedge clk);
    corrupt = '0;
    chk("pre_reset_error", {31'd0, error}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared_outputs("async_reset", 1'b0);
    en = 1'b0; auto_yumi = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    en = 1'b1; auto_yumi = 1'b1;
    @(negedge clk);
    chk("rst_v",      {31'd0, v_o}, 32'd1);
    chk("rst_beat0",  data_o,       32'h76543210);
    @(negedge clk);
    chk("rst_beat1",  data_o,       32'h87654321);
    en = 1'b0;
    @(negedge clk);
    auto_yumi = 1'b0;
    chk("rst_recv",   received,     32'd2);
    chk("rst_error",  {31'd0, error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_link_sdr_traffic_node.md
Name: bsg_link_sdr_traffic_node

Overview:
- Single-clock, parametrised traffic generator and checker for exercising SDR link channels in loopback or end-to-end.
- Generator drives a deterministic multi-channel pattern on a valid/yumi interface. Checker regenerates the same pattern and compares it against data accepted on a valid/ready interface.
- Counts sent and received beats, stops after a programmable beat limit, and reports the first mismatching channel.
- Supersedes the fixed-pattern, dual-clock test node with selectable pattern mode, a beat limit, synchronous clear and error localisation.

Parameters:
- num_channels_p, 8, number of link channels (≥1).
- channel_width_p, 4, bits per channel (≥2).
- count_width_p, 32, width of beat counters and limit.
- Derived: width_lp = num_channels_p*channel_width_p; chan_id_width_lp = max(1, ceil(log2(num_channels_p))).

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear pulse; samples mode_i.
- en_i  in  1  generator enable.
- mode_i  in  1  pattern select: 0 = counter, 1 = walking-one.
- limit_i  in  count_width_p  beat limit; 0 = unlimited.
- v_o  out  1  generator data valid.
- data_o  out  width_lp  generator data.
- yumi_i  in  1  downstream consumed data_o; legal only when v_o=1.
- v_i  in  1  checker data valid.
- data_i  in  width_lp  checker data.
- ready_o  out  1  checker ready.
- sent_o  out  count_width_p  beats sent (v_o & yumi_i).
- received_o  out  count_width_p  beats accepted (v_i & ready_o).
- error_o  out  1  sticky mismatch flag.
- error_chan_o  out  chan_id_width_lp  lowest mismatching channel of the first bad beat.
- done_o  out  1  generator reached limit.

Behaviour:
- Reset (reset_n_i=0, takes effect immediately, no clock needed):
  - v_o=0, ready_o=0, sent_o=0, received_o=0, error_o=0, error_chan_o=0, done_o=0.
  - Generator FSM goes to IDLE; both pattern states load the seed; mode register = 0.
- clear_i=1 (synchronous, overrides every other input that cycle):
  - Same state as reset, except ready_o=1.
  - mode register <= mode_i.
  - Any in-flight v_o drops; the bench must not assert yumi_i in the clear cycle.
- ready_o: registered; goes to 1 on the first clock edge after reset release and then stays 1. Checker never backpressures.
- Pattern, beat k (per channel slice c):
  - Counter mode: slice c = (c + k) mod 2^channel_width_p.
  - Walking-one mode: slice c = 1 << ((c + k) mod channel_width_p).
  - Seed is beat 0.
  - Generator and checker hold independent copies of the pattern state. Each advances one beat only on its own handshake.
- Generator FSM states: IDLE, RUN, DONE.
  - IDLE: v_o=0. If en_i=1 and limit not reached, go to RUN; v_o=1 from the next cycle (1-cycle latency).
  - RUN: v_o=1; data_o stable until yumi_i.
    - On yumi_i: sent_o+1 and pattern advances. Next beat is presented in the following cycle (full throughput, no bubble).
    - After yumi_i: if limit_i≠0 and the new sent_o == limit_i, go to DONE. Otherwise, if en_i=0, go to IDLE. Otherwise stay in RUN.
    - en_i=0 while v_o=1 without yumi_i: v_o stays high, data held, until yumi_i.
  - DONE: v_o=0, done_o=1; stays in DONE until clear_i or reset.
  - Re-enabling from IDLE continues the sequence with no gap or repeat.
- Checker, on v_i & ready_o:
  - received_o+1 and the expected pattern advances.
  - Compare data_i to the expected word per channel slice.
  - On mismatch: error_o=1 on the next cycle, sticky.
  - error_chan_o captures the lowest mismatching channel index only when error_o was 0; later errors do not overwrite it.
  - Checking continues after an error; the expected sequence keeps advancing and does not resynchronise.
- Counters saturate at all-ones and do not wrap.
- limit_i is sampled every cycle; the bench holds it static while in RUN.
- Simultaneous generate and check events in the same cycle are independent.

Test Plan:
- 8x4, counter mode, limit_i=100, data_o looped to data_i, yumi_i=v_o -> sent_o=received_o=100, done_o=1, error_o=0, exactly 100 consecutive v_o cycles.
- Random yumi_i (50%) in loopback -> data_o/v_o stable whenever yumi_i=0; sent_o=received_o; no errors; first word slices 0..7, second word 1..8.
- Loopback with beat 10, channel 5 XOR 0x1, then beat 20, channel 2 corrupted -> error_o=1 in the cycle after beat 10; error_chan_o=5 and unchanged afterwards; received_o continues.
- clear_i with mode_i=1, then run -> channel 0 slice over beats 0-4 = 0x1,0x2,0x4,0x8,0x1; channel 1 slice at beat 0 = 0x2.
- en_i dropped in RUN with yumi_i held low 3 cycles -> v_o stays 1 until yumi_i, then IDLE; after re-enable, next word is beat k+1 and no error is raised.
- reset_n_i asserted mid-run between clock edges -> v_o, ready_o, counters and error outputs drop to 0 immediately; after release and re-enable, the sequence restarts at beat 0.
